fdivsqrt_r4_iter: RTL and testbench



---
 rtl/fdivsqrt_r4_iter.sv | 185 ++++++++++++++++++
 tb/tb_fdivsqrt_r4_iter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdivsqrt_r4_iter.sv
// Radix-4 SRT mantissa divider iteration unit. It keeps an exact residual, picks one signed digit per
// cycle and builds the quotient on the fly in the U/UM pair, then hands out a truncated quotient plus sticky.
module fdivsqrt_r4_iter #(
  parameter  int WIDTH  = 16,
  parameter  int ITER   = 10,
  localparam int QWIDTH = 2 * ITER
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH:0]    x,
  input  logic [WIDTH:0]    d,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [QWIDTH-1:0] q,
  output logic              sticky,
  output logic              busy
);

  // Residual: sign, 3 integer bits and WIDTH+2 fraction bits, LSB weight 2^-(WIDTH+2).
  localparam int WW = WIDTH + 6;
  localparam int EW = WW + 2;
  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [WW-1:0]     w_q, w_d;
  logic [WIDTH:0]    d_q, d_d;
  logic [QWIDTH-1:0] u_q, u_d;
  logic [QWIDTH-1:0] um_q, um_d;
  logic [QWIDTH-1:0] mask_q, mask_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              bad_q, bad_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic [QWIDTH-1:0] q_q, q_d;
  logic              sticky_q, sticky_d;

  logic signed [EW-1:0] w4, dv, half_d, three_half_d, sub_val, w_full;
  logic [3:0]           dig;
  logic [1:0]           u_val, um_val;
  logic [QWIDTH-1:0]    u_base, um_base, u_new, um_new;
  logic [WW-1:0]        w_new;

  // Digit selection and exact residual update; all compares are against the full-width residual.
  always_comb begin
    w4           = $signed({w_q, 2'b00});
    dv           = $signed({{(EW-WIDTH-3){1'b0}}, d_q, 2'b00});
    half_d       = dv >>> 1;
    three_half_d = dv + half_d;
    if (w4 >= three_half_d)       dig = 4'b1000;
    else if (w4 >= half_d)        dig = 4'b0100;
    else if (w4 >= -half_d)       dig = 4'b0000;
    else if (w4 >= -three_half_d) dig = 4'b0010;
    else                          dig = 4'b0001;
    case (dig)
      4'b1000: sub_val = dv <<< 1;
      4'b0100: sub_val = dv;
      4'b0010: sub_val = -dv;
      4'b0001: sub_val = -(dv <<< 1);
      default: sub_val = '0;
    endcase
    w_full = w4 - sub_val;
    w_new  = w_full[WW-1:0];
  end

  // On-the-fly conversion: the current digit slot is always zero in both U and UM, so ORing the
  // 2-bit slot value under the shifting mask replaces any carry-propagating add.
  always_comb begin
    case (dig)
      4'b1000: begin u_val = 2'd2; um_val = 2'd1; u_base = u_q;  um_base = u_q;  end
      4'b0100: begin u_val = 2'd1; um_val = 2'd0; u_base = u_q;  um_base = u_q;  end
      4'b0010: begin u_val = 2'd3; um_val = 2'd2; u_base = um_q; um_base = um_q; end
      4'b0001: begin u_val = 2'd2; um_val = 2'd1; u_base = um_q; um_base = um_q; end
      default: begin u_val = 2'd0; um_val = 2'd3; u_base = u_q;  um_base = um_q; end
    endcase
    u_new  = u_base  | ({QWIDTH{u_val[1]}}  & (mask_q << 1)) | ({QWIDTH{u_val[0]}}  & mask_q);
    um_new = um_base | ({QWIDTH{um_val[1]}} & (mask_q << 1)) | ({QWIDTH{um_val[0]}} & mask_q);
  end

  // Next-state and output logic for the IDLE -> ITER -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    d_d         = d_q;
    u_d         = u_q;
    um_d        = um_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    bad_d       = bad_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    q_d         = q_q;
    sticky_d    = sticky_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          d_d        = d;
          w_d        = {{(WW-WIDTH-1){1'b0}}, x};
          u_d        = '0;
          um_d       = '0;
          cnt_d      = '0;
          mask_d     = {{(QWIDTH-1){1'b0}}, 1'b1} << (QWIDTH - 2);
          bad_d      = ~d[WIDTH];
          state_d    = S_ITER;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_ITER: begin
        w_d    = w_new;
        u_d    = u_new;
        um_d   = um_new;
        mask_d = mask_q >> 2;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          state_d     = S_DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          // A negative final residual means the last digit overshot by one ulp; UM is U minus one ulp.
          if (bad_q)           q_d = '0;
          else if (w_new[WW-1]) q_d = um_new;
          else                 q_d = u_new;
          sticky_d = bad_q | (w_new != '0);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      w_q         <= '0;
      d_q         <= '0;
      u_q         <= '0;
      um_q        <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      bad_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      q_q         <= '0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      d_q         <= d_d;
      u_q         <= u_d;
      um_q        <= um_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      bad_q       <= bad_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      q_q         <= q_d;
      sticky_q    <= sticky_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign q         = q_q;
  assign sticky    = sticky_q;

endmodule

// File: tb/tb_fdivsqrt_r4_iter.sv
// Self-checking bench for fdivsqrt_r4_iter: directed cases plus randomized operands checked against
// an exact integer-division reference model.
module tb_fdivsqrt_r4_iter;

  localparam int WIDTH  = 16;
  localparam int ITER   = 10;
  localparam int QWIDTH = 2 * ITER;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH:0]    x;
  logic [WIDTH:0]    d;
  logic              out_valid;
  logic              out_ready;
  logic [QWIDTH-1:0] q;
  logic              sticky;
  logic              busy;

  int tests = 0;
  int fails = 0;

  fdivsqrt_r4_iter #(.WIDTH(WIDTH), .ITER(ITER)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .d(d), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .sticky(sticky), .busy(busy)
  );

  always #5 clk = ~clk;

  // Exact reference: floor(x*2^QWIDTH / 4d) and remainder test; MSB-clear divisor forces q=0, sticky=1.
  function automatic void ref_model(input logic [WIDTH:0] xi, input logic [WIDTH:0] di,
                                    output logic [QWIDTH-1:0] eq, output logic es);
    longint unsigned num, den;
    if (!di[WIDTH]) begin
      eq = '0;
      es = 1'b1;
    end else begin
      num = longint'(xi) << QWIDTH;
      den = 4 * longint'(di);
      eq  = QWIDTH'(num / den);
      es  = (num % den) != 0;
    end
  endfunction

  // Runs one operation from IDLE with out_ready=1; returns result, latency and invariant status.
  task automatic run_op(input logic [WIDTH:0] xi, input logic [WIDTH:0] di,
                        output logic [QWIDTH-1:0] rq, output logic rs,
                        output int lat, output logic inv_ok);
    longint unsigned k, umexp;
    logic signed [WIDTH+5:0] wv;
    longint wabs;
    inv_ok   = 1'b1;
    x        = xi;
    d        = di;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x        = $urandom;
    d        = $urandom;
    lat      = 0;
    while (!out_valid && lat < 100) begin
      if (busy && di[WIDTH]) begin
        k     = (longint'(1) << QWIDTH) >> (2 * int'(dut.cnt_q));
        umexp = (longint'(dut.u_q) - k) & ((longint'(1) << QWIDTH) - 1);
        wv    = dut.w_q;
        wabs  = (wv < 0) ? -longint'(wv) : longint'(wv);
        if (longint'(dut.um_q) != umexp || wabs > (longint'(dut.d_q) << 1)) inv_ok = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    rq = q;
    rs = sticky;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0; d = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || q !== '0 || sticky !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_state: got rdy=%b ov=%b busy=%b q=%h st=%b, want 1 0 0 00000 0",
               in_ready, out_valid, busy, q, sticky);
    end
  endtask

  task automatic test_directed();
    logic [WIDTH:0] xs [4] = '{17'h10000, 17'h18000, 17'h00000, 17'h10000};
    logic [WIDTH:0] ds [4] = '{17'h10000, 17'h10000, 17'h1FFFF, 17'h18000};
    logic [QWIDTH-1:0] qs [4] = '{20'h40000, 20'h60000, 20'h00000, 20'h2AAAA};
    logic ss [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [QWIDTH-1:0] rq;
    logic rs, ok;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(xs[i], ds[i], rq, rs, lat, ok);
      tests++;
      if (rq !== qs[i] || rs !== ss[i]) begin
        fails++;
        $display("[TB] FAIL directed_%0d: got q=%h st=%b, want q=%h st=%b", i, rq, rs, qs[i], ss[i]);
      end
      tests++;
      if (lat != ITER) begin
        fails++;
        $display("[TB] FAIL latency_%0d: got %0d edges, want %0d", i, lat, ITER);
      end
    end
  endtask

  task automatic test_random();
    logic [WIDTH:0] xi, di;
    logic [QWIDTH-1:0] rq, eq;
    logic rs, es, ok;
    int lat;
    for (int i = 0; i < 2000; i++) begin
      xi = WIDTH'(0) | 17'($urandom);
      di = 17'($urandom) | 17'h10000;
      if (i < 8) xi = (i % 2 == 0) ? 17'h1FFFF : 17'h00001;
      if (i >= 8 && i < 12) di = (i % 2 == 0) ? 17'h10000 : 17'h1FFFF;
      ref_model(xi, di, eq, es);
      run_op(xi, di, rq, rs, lat, ok);
      tests++;
      if (rq !== eq || rs !== es) begin
        fails++;
        $display("[TB] FAIL random x=%h d=%h: got q=%h st=%b, want q=%h st=%b", xi, di, rq, rs, eq, es);
      end
      tests++;
      if (ok !== 1'b1) begin
        fails++;
        $display("[TB] FAIL invariant x=%h d=%h: got violated, want UM==U-K and |W|<=d/2", xi, di);
      end
    end
  endtask

  task automatic test_hold();
    logic [QWIDTH-1:0] eq, rq;
    logic es, rs, ok;
    int lat;
    out_ready = 1'b0;
    x = 17'h1ABCD; d = 17'h13579;
    ref_model(x, d, eq, es);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    tests++;
    if (lat != ITER) begin
      fails++;
      $display("[TB] FAIL hold_latency: got %0d, want %0d", lat, ITER);
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; x = 17'($urandom); d = 17'($urandom) | 17'h10000;
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || q !== eq || sticky !== es) begin
        fails++;
        $display("[TB] FAIL hold_cycle_%0d: got ov=%b rdy=%b busy=%b q=%h st=%b, want 1 0 0 %h %b",
                 c, out_valid, in_ready, busy, q, sticky, eq, es);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL hold_release: got ov=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    ref_model(17'h0C000, 17'h10000, eq, es);
    run_op(17'h0C000, 17'h10000, rq, rs, lat, ok);
    tests++;
    if (rq !== eq || rs !== es) begin
      fails++;
      $display("[TB] FAIL hold_next_op: got q=%h st=%b, want q=%h st=%b", rq, rs, eq, es);
    end
  endtask

  task automatic test_back_to_back();
    logic [QWIDTH-1:0] ea, eb;
    logic sa, sb;
    int lat;
    ref_model(17'h15555, 17'h1C000, ea, sa);
    ref_model(17'h0F0F0, 17'h11111, eb, sb);
    x = 17'h15555; d = 17'h1C000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    tests++;
    if (q !== ea || sticky !== sa || in_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_first: got q=%h st=%b rdy=%b, want q=%h st=%b rdy=0", q, sticky, in_ready, ea, sa);
    end
    x = 17'h0F0F0; d = 17'h11111; in_valid = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_idle: got ov=%b rdy=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL b2b_accept: got busy=%b, want 1", busy);
    end
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    tests++;
    if (q !== eb || sticky !== sb || lat != ITER) begin
      fails++;
      $display("[TB] FAIL b2b_second: got q=%h st=%b lat=%0d, want q=%h st=%b lat=%0d",
               q, sticky, lat, eb, sb, ITER);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [QWIDTH-1:0] rq;
    logic rs, ok;
    int lat;
    x = 17'h1FFFF; d = 17'h10001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || q !== '0) begin
      fails++;
      $display("[TB] FAIL reset_mid: got ov=%b busy=%b rdy=%b q=%h, want 0 0 1 00000",
               out_valid, busy, in_ready, q);
    end
    run_op(17'h10000, 17'h08000, rq, rs, lat, ok);
    tests++;
    if (rq !== '0 || rs !== 1'b1 || lat != ITER) begin
      fails++;
      $display("[TB] FAIL bad_divisor: got q=%h st=%b lat=%0d, want q=00000 st=1 lat=%0d", rq, rs, lat, ITER);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
